// File: rtl/isk_arb_if.sv
// Reservation bus between the MERA-400 interface-switch arbiter and its
// four masters (CPU0, CPU1, spare slot, I/O bus). Bit i of every vector
// belongs to master i.
//
// Handshake: zg[i] is a level request, held high for as long as master i
// needs the bus; zw[i] is the grant. A grant stays up while zg[i] stays
// high (unless the hold watchdog revokes it); dropping zg[i] is the release.
// zz[i] tells master i that somebody else owns the bus.
interface isk_arb_if;
    logic [1:4] zg;
    logic [1:4] zw;
    logic [1:4] zz;
    logic [0:1] owner;
    logic       busy;
    logic       timeout_err;
    logic [1:0] dbg_state;

    // Requester side: drives requests, observes grants and status.
    modport master (
        output zg,
        input  zw, zz, owner, busy, timeout_err, dbg_state
    );

    // Arbiter side.
    modport slave (
        input  zg,
        output zw, zz, owner, busy, timeout_err, dbg_state
    );
endinterface

// File: rtl/isk_arb.sv
// Bus reservation arbiter for the MERA-400 system bus interface switch.
// Grants the bus to one master at a time, inserts a dead gap between owners
// so drivers can turn around, and optionally revokes a master that holds the
// bus for too long. All outputs are registered.
module isk_arb #(
    parameter logic        RR         = 1'b0,   // 0: fixed priority, 1: round-robin
    parameter logic [3:0]  GAP_CYCLES = 4'd1,   // idle cycles after a release
    parameter logic [15:0] TIMEOUT    = 16'd0   // max grant length, 0 = no watchdog
) (
    input  logic         clk_sys,
    input  logic         reset,
    isk_arb_if.slave     bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  req;        // req[k] = request of master k+1
    logic [3:0]  zw_q;
    logic [3:0]  zz_q;
    logic [1:0]  owner_q;
    logic        busy_q;
    logic        tmo_err_q;
    logic [3:0]  mask_q;     // masters revoked by the watchdog, not yet released
    logic [1:0]  rr_ptr;     // last winner, round-robin search starts after it
    logic [3:0]  gap_cnt;
    logic [15:0] hold_cnt;

    logic [3:0]  elig;
    logic        win_ok;
    logic [1:0]  win_idx;
    logic [1:0]  cand;
    logic        owner_req;
    logic        tmo_hit;

    // Internal vectors are little-endian 0..3; the bus uses master numbers 1..4.
    assign req = {bus.zg[4], bus.zg[3], bus.zg[2], bus.zg[1]};

    assign bus.zw          = {zw_q[0], zw_q[1], zw_q[2], zw_q[3]};
    assign bus.zz          = {zz_q[0], zz_q[1], zz_q[2], zz_q[3]};
    assign bus.owner       = owner_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = tmo_err_q;
    assign bus.dbg_state   = state;

    // A master revoked by the watchdog must drop its request before it counts again.
    assign elig = req & ~mask_q;

    // The owner still wants the bus this cycle.
    assign owner_req = req[owner_q];

    // Watchdog fires on the edge where the hold counter would reach TIMEOUT.
    assign tmo_hit = (TIMEOUT != 16'd0) &&
                     (({1'b0, hold_cnt} + 17'd1) == {1'b0, TIMEOUT});

    // Winner search: fixed order 1..4, or pointer+1 .. pointer when round-robin.
    always_comb begin
        win_ok  = 1'b0;
        win_idx = 2'd0;
        cand    = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = RR ? (rr_ptr + 2'(k + 1)) : 2'(k);
            if (!win_ok && elig[cand]) begin
                win_ok  = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Arbiter FSM with all outputs, mask, pointer and counters registered.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= S_IDLE;
            zw_q      <= 4'd0;
            zz_q      <= 4'd0;
            owner_q   <= 2'd0;
            busy_q    <= 1'b0;
            tmo_err_q <= 1'b0;
            mask_q    <= 4'd0;
            rr_ptr    <= 2'd3;
            gap_cnt   <= 4'd0;
            hold_cnt  <= 16'd0;
        end else begin
            tmo_err_q <= 1'b0;
            // A low request always clears that master's mask bit.
            mask_q    <= mask_q & req;

            case (state)
                S_IDLE: begin
                    if (win_ok) begin
                        state    <= S_GRANT;
                        zw_q     <= 4'b0001 << win_idx;
                        zz_q     <= ~(4'b0001 << win_idx);
                        busy_q   <= 1'b1;
                        owner_q  <= win_idx;
                        rr_ptr   <= win_idx;
                        hold_cnt <= 16'd0;
                    end
                end

                S_GRANT: begin
                    // Other requests never preempt; only release or watchdog end a grant.
                    if (!owner_req || tmo_hit) begin
                        zw_q   <= 4'd0;
                        zz_q   <= 4'd0;
                        busy_q <= 1'b0;
                        // A release on the watchdog edge wins: no error, no mask.
                        if (owner_req) begin
                            tmo_err_q       <= 1'b1;
                            mask_q[owner_q] <= 1'b1;
                        end
                        if (GAP_CYCLES != 4'd0) begin
                            state   <= S_GAP;
                            gap_cnt <= GAP_CYCLES;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 16'd1;
                    end
                end

                S_GAP: begin
                    // Requests are ignored here and picked up again in IDLE.
                    if (gap_cnt <= 4'd1) begin
                        state   <= S_IDLE;
                        gap_cnt <= 4'd0;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    zw_q  <= 4'd0;
                    zz_q  <= 4'd0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Bus exclusivity: never more than one grant at a time.
    a_zw_onehot: assert property (@(posedge clk_sys) disable iff (reset) $onehot0(zw_q));

    // zz is exactly the complement of the grant while the bus is owned.
    a_zz_match: assert property (@(posedge clk_sys) disable iff (reset)
                                 (zz_q == (busy_q ? ~zw_q : 4'd0)));

endmodule

// File: tb/tb_isk_arb.sv
// Directed bench for isk_arb. Three instances cover fixed priority with the
// watchdog (A), round-robin (B) and a zero-length gap (C). Each test
// restarts its cycle numbering at "cycle 0" = the cycle the first request
// is driven; inputs are driven and outputs sampled 1 ns after the rising edge.
module tb_isk_arb;

    logic clk_sys;
    logic reset;

    int n_checks;
    int n_errors;

    logic [2:0] exp_q[$];

    isk_arb_if bus_a();
    isk_arb_if bus_b();
    isk_arb_if bus_c();

    isk_arb #(.RR(1'b0), .GAP_CYCLES(4'd1), .TIMEOUT(16'd8)) dut_a (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus_a.slave)
    );

    isk_arb #(.RR(1'b1), .GAP_CYCLES(4'd1), .TIMEOUT(16'd0)) dut_b (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus_b.slave)
    );

    isk_arb #(.RR(1'b0), .GAP_CYCLES(4'd0), .TIMEOUT(16'd0)) dut_c (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus_c.slave)
    );

    // Clock and run-time guard.
    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "time limit");
    end

    // Advance one cycle; land 1 ns after the rising edge.
    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Let a bus drain back to IDLE with no requests.
    task automatic settle_a();
        bus_a.zg = 4'b0000;
        repeat (4) step();
    endtask

    function automatic int master_of(input logic [1:4] v);
        int m;
        m = 0;
        for (int i = 1; i <= 4; i++) if (v[i]) m = i;
        return m;
    endfunction

    initial begin
        logic [1:4] cur;
        logic [1:4] prev;
        logic [1:4] zg_next;
        int held[1:4];
        int m;

        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        bus_a.zg = 4'b0000;
        bus_b.zg = 4'b0000;
        bus_c.zg = 4'b0000;
        repeat (3) step();

        // Reset state
        check("rst_zw", bus_a.zw, 4'b0000);
        check("rst_zz", bus_a.zz, 4'b0000);
        check("rst_busy", bus_a.busy, 1'b0);
        check("rst_owner", bus_a.owner, 2'd0);
        check("rst_terr", bus_a.timeout_err, 1'b0);
        check("rst_state", bus_a.dbg_state, 2'd0);

        // Single request: master 1
        reset = 1'b0;
        bus_a.zg = 4'b1000;                     // cycle 0
        step();                                 // cycle 1
        check("t1_zw", bus_a.zw, 4'b1000);
        check("t1_zz", bus_a.zz, 4'b0111);
        check("t1_busy", bus_a.busy, 1'b1);
        check("t1_owner", bus_a.owner, 2'd0);
        settle_a();
        check("t1_idle_zw", bus_a.zw, 4'b0000);
        check("t1_idle_busy", bus_a.busy, 1'b0);

        // Fixed priority and gap: zg = 1001, master 1 drops at cycle 5
        bus_a.zg = 4'b1001;                     // cycle 0
        for (int c = 1; c <= 5; c++) begin
            step();
            check($sformatf("t2_zw_c%0d", c), bus_a.zw, 4'b1000);
        end
        bus_a.zg = 4'b0001;                     // release during cycle 5
        step();                                 // cycle 6: gap
        check("t2_zw_c6", bus_a.zw, 4'b0000);
        check("t2_owner_c6", bus_a.owner, 2'd0);
        step();                                 // cycle 7: idle
        check("t2_zw_c7", bus_a.zw, 4'b0000);
        step();                                 // cycle 8
        check("t2_zw_c8", bus_a.zw, 4'b0001);
        check("t2_zz_c8", bus_a.zz, 4'b1110);
        check("t2_owner_c8", bus_a.owner, 2'd3);
        settle_a();

        // Watchdog: master 2 holds, master 3 waits
        bus_a.zg = 4'b0110;                     // cycle 0
        for (int c = 1; c <= 8; c++) begin
            step();
            check($sformatf("t4_zw_c%0d", c), bus_a.zw, 4'b0100);
            check($sformatf("t4_terr_c%0d", c), bus_a.timeout_err, 1'b0);
        end
        step();                                 // cycle 9: revoked
        check("t4_zw_c9", bus_a.zw, 4'b0000);
        check("t4_terr_c9", bus_a.timeout_err, 1'b1);
        check("t4_busy_c9", bus_a.busy, 1'b0);
        step();                                 // cycle 10: idle
        check("t4_terr_c10", bus_a.timeout_err, 1'b0);
        check("t4_zw_c10", bus_a.zw, 4'b0000);
        step();                                 // cycle 11: master 3
        check("t4_zw_c11", bus_a.zw, 4'b0010);
        check("t4_owner_c11", bus_a.owner, 2'd2);
        bus_a.zg = 4'b0100;                     // master 3 releases, master 2 still high
        for (int c = 12; c <= 15; c++) begin
            step();
            check($sformatf("t4_masked_c%0d", c), bus_a.zw, 4'b0000);
        end
        bus_a.zg = 4'b0000;                     // cycle 15: master 2 drops once
        step();
        bus_a.zg = 4'b0100;                     // cycle 16
        step();                                 // cycle 17
        check("t4_regrant_c17", bus_a.zw, 4'b0100);
        settle_a();

        // Release on the very edge the hold counter reaches TIMEOUT
        bus_a.zg = 4'b0100;                     // cycle 0
        repeat (8) step();                      // cycle 8, last allowed grant cycle
        check("t6_zw_c8", bus_a.zw, 4'b0100);
        bus_a.zg = 4'b0000;
        step();                                 // cycle 9
        check("t6_terr_c9", bus_a.timeout_err, 1'b0);
        check("t6_zw_c9", bus_a.zw, 4'b0000);
        bus_a.zg = 4'b0100;
        step();                                 // cycle 10
        check("t6_terr_c10", bus_a.timeout_err, 1'b0);
        step();                                 // cycle 11
        check("t6_regrant_c11", bus_a.zw, 4'b0100);
        settle_a();

        // Reset during master 4's grant
        bus_a.zg = 4'b0001;                     // cycle 0
        step();                                 // cycle 1
        check("t5_zw_c1", bus_a.zw, 4'b0001);
        check("t5_owner_c1", bus_a.owner, 2'd3);
        step();                                 // cycle 2
        reset = 1'b1;
        step();                                 // cycle 3
        check("t5_rst_zw", bus_a.zw, 4'b0000);
        check("t5_rst_zz", bus_a.zz, 4'b0000);
        check("t5_rst_busy", bus_a.busy, 1'b0);
        check("t5_rst_owner", bus_a.owner, 2'd0);
        check("t5_rst_terr", bus_a.timeout_err, 1'b0);
        reset = 1'b0;
        step();                                 // cycle 4
        check("t5_zw_c4", bus_a.zw, 4'b0001);
        settle_a();

        // Zero gap: master 3 releases, waiting master 4 sees one idle cycle
        bus_c.zg = 4'b0011;                     // cycle 0
        step();                                 // cycle 1
        check("gap0_zw_c1", bus_c.zw, 4'b0010);
        bus_c.zg = 4'b0001;
        step();                                 // cycle 2
        check("gap0_zw_c2", bus_c.zw, 4'b0000);
        check("gap0_state_c2", bus_c.dbg_state, 2'd0);
        step();                                 // cycle 3
        check("gap0_zw_c3", bus_c.zw, 4'b0001);
        bus_c.zg = 4'b0000;

        // Round-robin: everyone requests; each holds 3 cycles, drops for 1
        exp_q = {3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
        for (int i = 1; i <= 4; i++) held[i] = 0;
        prev = 4'b0000;
        bus_b.zg = 4'b1111;                     // cycle 0
        for (int cyc = 0; cyc < 80 && exp_q.size() > 0; cyc++) begin
            step();
            cur = bus_b.zw;
            check("rr_onehot", {31'd0, $onehot0(cur)}, 32'd1);
            if (cur != 4'b0000 && prev == 4'b0000) begin
                m = master_of(cur);
                check("rr_order", m, exp_q[0]);
                check("rr_owner", bus_b.owner, m - 1);
                void'(exp_q.pop_front());
            end
            zg_next = 4'b1111;
            for (int i = 1; i <= 4; i++) begin
                held[i] = cur[i] ? held[i] + 1 : 0;
                if (held[i] == 3) zg_next[i] = 1'b0;
            end
            bus_b.zg = zg_next;
            prev = cur;
        end
        check("rr_grants_left", exp_q.size(), 0);
        bus_b.zg = 4'b0000;
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
